// File: rtl/corr_pkt_arbiter_if.sv
// -----------------------------------------------------------------------------
// corr_pkt_arbiter_if
//   Bundles the correlator-facing and FIFO-facing signals of corr_pkt_arbiter.
//
//   Channel side : i_wrap (per-channel wrap strobes), i_counts (per-channel
//                  {symdiff,isect,y,x} bytes, channel c at [32*c +: 32])
//   FIFO side    : i_fifoNEntries (occupancy), o_push / o_data (push port)
//   Status       : o_busy (packet being emitted), o_pending (slot flags),
//                  o_dropCount (saturating dropped-wrap count)
//
//   master : the arbiter itself
//   slave  : whoever drives the channels and owns the FIFO
// -----------------------------------------------------------------------------
interface corr_pkt_arbiter_if #(
  parameter int N_CHAN     = 4,
  parameter int FIFO_DEPTH = 50
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [N_CHAN-1:0]    i_wrap;
  logic [32*N_CHAN-1:0] i_counts;
  logic [CNT_W-1:0]     i_fifoNEntries;
  logic                 o_push;
  logic [7:0]           o_data;
  logic                 o_busy;
  logic [N_CHAN-1:0]    o_pending;
  logic [7:0]           o_dropCount;

  modport master (
    input  i_wrap, i_counts, i_fifoNEntries,
    output o_push, o_data, o_busy, o_pending, o_dropCount
  );

  modport slave (
    output i_wrap, i_counts, i_fifoNEntries,
    input  o_push, o_data, o_busy, o_pending, o_dropCount
  );
endinterface

// File: rtl/corr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// corr_pkt_arbiter
//   Round-robin scheduler sharing one byte-wide packet FIFO between N_CHAN
//   correlator channels. Each channel holds one pending packet; when the FIFO
//   has room for a whole packet the next channel (round-robin) is granted and
//   its packet is pushed as six bytes:
//     channel index, window number, x, y, isect, symdiff
//   Wraps arriving while a channel's slot is full are dropped and counted,
//   but the channel's window number still advances so the host sees the gap.
//
// Ports
//   i_clk    : clock
//   i_rst    : synchronous active-high reset (has priority over i_flush)
//   i_cg     : clock-gate enable; low freezes all state and masks o_push
//   i_flush  : synchronous abort of pending and in-flight packets
//   bus      : corr_pkt_arbiter_if.master (wrap/counts in, FIFO push out,
//              busy/pending/dropCount status out)
// -----------------------------------------------------------------------------
module corr_pkt_arbiter #(
  parameter int N_CHAN     = 4,
  parameter int FIFO_DEPTH = 50
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic               i_flush,
  corr_pkt_arbiter_if.master bus
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int DROP_W = $clog2(N_CHAN + 1);

  typedef enum logic {IDLE, EMIT} stateT;

  stateT             stateReg, stateNext;
  logic [PTR_W-1:0]  rrPtrReg, rrPtrNext;
  logic [2:0]        byteIdxReg, byteIdxNext;
  logic [47:0]       bufReg, bufNext;
  logic [7:0]        dataReg, dataNext;
  logic [7:0]        dropCountReg, dropCountNext;

  logic [N_CHAN-1:0] pendingVec;
  logic [N_CHAN-1:0] grantVec;
  logic [N_CHAN-1:0] dropVec;
  logic [31:0]       shadowArr [N_CHAN];
  logic [7:0]        winNumShadowArr [N_CHAN];

  logic              fifoRoom;
  logic              grant;
  logic              found;
  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  grantIdx;
  logic [DROP_W-1:0] dropNum;
  logic [9:0]        dropSum;

  // One bit wider than the occupancy so the +6 can never wrap.
  assign fifoRoom = ({1'b0, bus.i_fifoNEntries} + (CNT_W+1)'(6)) <= (CNT_W+1)'(FIFO_DEPTH);

  // Grants only happen from IDLE, so the cycle that returns to IDLE after
  // byte 5 can never also grant.
  assign grant = i_cg && !i_flush && (stateReg == IDLE) && (|pendingVec) && fifoRoom;

  // ---------------------------------------------------------------------------
  // Per-channel slot: pending flag, captured counts, window numbers.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CHAN; gi++) begin : gChan
    logic        pendingReg;
    logic [31:0] shadowReg;
    logic [7:0]  winNumShadowReg;
    logic [7:0]  winNumReg;
    logic        wrapLive;

    assign wrapLive = i_cg && bus.i_wrap[gi];
    // A wrap is only a drop if the slot stays occupied across this edge.
    assign dropVec[gi] = wrapLive && !i_flush && pendingReg && !grantVec[gi];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        pendingReg      <= 1'b0;
        shadowReg       <= '0;
        winNumShadowReg <= '0;
        winNumReg       <= '0;
      end else if (i_cg) begin
        // The window number counts every wrap, even dropped or flushed ones.
        if (bus.i_wrap[gi]) begin
          winNumReg <= winNumReg + 8'd1;
        end
        if (i_flush) begin
          pendingReg <= 1'b0;
        end else if (bus.i_wrap[gi] && (!pendingReg || grantVec[gi])) begin
          // Granted-this-cycle slot is being copied out, so it can be refilled.
          shadowReg       <= bus.i_counts[32*gi +: 32];
          winNumShadowReg <= winNumReg;
          pendingReg      <= 1'b1;
        end else if (grantVec[gi]) begin
          pendingReg <= 1'b0;
        end
      end
    end

    assign pendingVec[gi]      = pendingReg;
    assign shadowArr[gi]       = shadowReg;
    assign winNumShadowArr[gi] = winNumShadowReg;
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first pending channel at or above rrPtr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    grantIdx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      cand = {1'b0, rrPtrReg} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CHAN)) begin
        cand = cand - (PTR_W+1)'(N_CHAN);
      end
      if (!found && pendingVec[cand[PTR_W-1:0]]) begin
        found    = 1'b1;
        grantIdx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grantVec = '0;
    if (grant) begin
      grantVec[grantIdx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: all simultaneous drops are summed, then saturated.
  // ---------------------------------------------------------------------------
  always_comb begin
    dropNum = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      dropNum = dropNum + DROP_W'(dropVec[i]);
    end
    dropSum       = {2'b00, dropCountReg} + 10'(dropNum);
    dropCountNext = dropCountReg;
    if (i_cg) begin
      if (i_flush) begin
        dropCountNext = '0;
      end else if (dropSum > 10'd255) begin
        dropCountNext = 8'hFF;
      end else begin
        dropCountNext = dropSum[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Emit FSM. dataReg always holds the byte being pushed; bufReg shifts down
  // so that its low byte is the one currently on o_data.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext   = stateReg;
    rrPtrNext   = rrPtrReg;
    byteIdxNext = byteIdxReg;
    bufNext     = bufReg;
    dataNext    = dataReg;
    if (i_cg) begin
      if (i_flush) begin
        stateNext   = IDLE;
        rrPtrNext   = '0;
        byteIdxNext = '0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (grant) begin
              bufNext     = {shadowArr[grantIdx], winNumShadowArr[grantIdx], 8'(grantIdx)};
              dataNext    = 8'(grantIdx);
              byteIdxNext = '0;
              rrPtrNext   = (grantIdx == PTR_W'(N_CHAN - 1)) ? '0 : grantIdx + PTR_W'(1);
              stateNext   = EMIT;
            end
          end
          EMIT: begin
            if (byteIdxReg == 3'd5) begin
              byteIdxNext = '0;
              stateNext   = IDLE;
            end else begin
              byteIdxNext = byteIdxReg + 3'd1;
              bufNext     = bufReg >> 8;
              dataNext    = bufReg[15:8];
            end
          end
          default: stateNext = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rrPtrReg     <= '0;
      byteIdxReg   <= '0;
      bufReg       <= '0;
      dataReg      <= '0;
      dropCountReg <= '0;
    end else begin
      rrPtrReg     <= rrPtrNext;
      byteIdxReg   <= byteIdxNext;
      bufReg       <= bufNext;
      dataReg      <= dataNext;
      dropCountReg <= dropCountNext;
    end
  end

  assign bus.o_busy      = (stateReg == EMIT);
  assign bus.o_push      = (stateReg == EMIT) && i_cg;
  assign bus.o_data      = dataReg;
  assign bus.o_pending   = pendingVec;
  assign bus.o_dropCount = dropCountReg;

endmodule

// File: tb/tb_corr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_corr_pkt_arbiter
//   Directed self-checking bench for corr_pkt_arbiter (N_CHAN=4, FIFO_DEPTH=50).
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   at that same point, so each tick() advances exactly one clock cycle.
// -----------------------------------------------------------------------------
module tb_corr_pkt_arbiter;
  localparam int N_CHAN     = 4;
  localparam int FIFO_DEPTH = 50;

  logic clk = 1'b0;
  logic rst;
  logic cg;
  logic flush;

  int errors = 0;
  int checks = 0;
  logic [7:0] pkt [6];

  corr_pkt_arbiter_if #(.N_CHAN(N_CHAN), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  corr_pkt_arbiter #(.N_CHAN(N_CHAN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_cg    (cg),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setCounts(input int ch, input logic [31:0] v);
    bus.i_counts[32*ch +: 32] = v;
  endtask

  task automatic doReset();
    rst                = 1'b1;
    cg                 = 1'b1;
    flush              = 1'b0;
    bus.i_wrap         = '0;
    bus.i_counts       = '0;
    bus.i_fifoNEntries = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for o_push, then records six bytes; ok drops if the
  // wait expires or the push strobe is not continuous.
  task automatic capPacket(output bit ok);
    int waitN = 0;
    ok = 1'b1;
    while (bus.o_push !== 1'b1 && waitN < 40) begin
      tick();
      waitN++;
    end
    for (int k = 0; k < 6; k++) begin
      if (bus.o_push !== 1'b1) ok = 1'b0;
      pkt[k] = bus.o_data;
      tick();
    end
    $display("pkt ok=%0d ch=%02h win=%02h x=%02h y=%02h isect=%02h symdiff=%02h",
             ok, pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5]);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.o_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", bus.o_push); end
    checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", bus.o_pending); end
    checks++; if (bus.o_dropCount !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.o_dropCount); end
  endtask

  task automatic test_single_wrap();
    logic [7:0] exp [6] = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    doReset();
    ticks(8);
    setCounts(2, 32'h44332211);
    bus.i_wrap = 4'b0100;
    tick();
    bus.i_wrap = '0;
    checks++; if (bus.o_pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", bus.o_pending); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_grant_busy: got %b want 0", bus.o_busy); end
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.o_push !== 1'b1 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_push%0d: push=%b busy=%b want 1,1", k, bus.o_push, bus.o_busy); end
      checks++; if (bus.o_data !== exp[k]) begin errors++; $display("FAIL single_data%0d: got %h want %h", k, bus.o_data, exp[k]); end
      tick();
    end
    checks++; if (bus.o_busy !== 1'b0 || bus.o_push !== 1'b0) begin errors++; $display("FAIL single_end: busy=%b push=%b want 0,0", bus.o_busy, bus.o_push); end
    checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL single_end_pending: got %b want 0000", bus.o_pending); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] expCh [3] = '{8'd1, 8'd2, 8'd0};
    logic [7:0] expX  [3] = '{8'h11, 8'hB5, 8'hA5};
    doReset();
    for (int c = 0; c < 4; c++) setCounts(c, 32'hD0C0B0A0 + 32'h01010101 * 32'(c));
    bus.i_wrap = 4'b1111;
    tick();
    bus.i_wrap = '0;
    for (int c = 0; c < 4; c++) begin
      capPacket(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_all_ok%0d: packet not pushed contiguously", c); end
      checks++; if (pkt[0] !== 8'(c)) begin errors++; $display("FAIL rr_all_ch%0d: got %h want %h", c, pkt[0], 8'(c)); end
      checks++; if (pkt[2] !== 8'hA0 + 8'(c) || pkt[5] !== 8'hD0 + 8'(c)) begin errors++; $display("FAIL rr_all_payload%0d: x=%h sd=%h want %h %h", c, pkt[2], pkt[5], 8'hA0 + 8'(c), 8'hD0 + 8'(c)); end
    end
    // Channel 1 granted; new wraps on 0 and 2 land in its grant cycle.
    doReset();
    setCounts(1, 32'h00000011);
    bus.i_wrap = 4'b0010;
    tick();
    setCounts(0, 32'h000000A5);
    setCounts(2, 32'h000000B5);
    bus.i_wrap = 4'b0101;
    tick();
    bus.i_wrap = '0;
    for (int p = 0; p < 3; p++) begin
      capPacket(ok);
      checks++; if (!ok || pkt[0] !== expCh[p]) begin errors++; $display("FAIL rr_order%0d: ok=%0d ch=%h want %h", p, ok, pkt[0], expCh[p]); end
      checks++; if (pkt[2] !== expX[p]) begin errors++; $display("FAIL rr_order_x%0d: got %h want %h", p, pkt[2], expX[p]); end
    end
  endtask

  task automatic test_drop_gap();
    bit ok;
    doReset();
    bus.i_fifoNEntries = 6'd45;
    setCounts(0, 32'h00000001);
    bus.i_wrap = 4'b0001;
    tick();
    setCounts(0, 32'h00000002);
    tick();
    setCounts(0, 32'h00000003);
    tick();
    bus.i_wrap = '0;
    tick();
    checks++; if (bus.o_dropCount !== 8'd2) begin errors++; $display("FAIL drop_count: got %0d want 2", bus.o_dropCount); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL drop_nogrant45: busy=%b want 0", bus.o_busy); end
    checks++; if (bus.o_pending !== 4'b0001) begin errors++; $display("FAIL drop_pending: got %b want 0001", bus.o_pending); end
    // 44 + 6 == 50 is exactly enough room.
    bus.i_fifoNEntries = 6'd44;
    tick();
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL drop_grant44: busy=%b want 1", bus.o_busy); end
    capPacket(ok);
    checks++; if (!ok || pkt[1] !== 8'd0 || pkt[2] !== 8'h01) begin errors++; $display("FAIL drop_first_pkt: ok=%0d win=%h x=%h want 00 01", ok, pkt[1], pkt[2]); end
    bus.i_fifoNEntries = '0;
    setCounts(0, 32'h00000004);
    bus.i_wrap = 4'b0001;
    tick();
    bus.i_wrap = '0;
    capPacket(ok);
    checks++; if (!ok || pkt[1] !== 8'd3 || pkt[2] !== 8'h04) begin errors++; $display("FAIL drop_gap_pkt: ok=%0d win=%h x=%h want 03 04", ok, pkt[1], pkt[2]); end
    checks++; if (bus.o_dropCount !== 8'd2) begin errors++; $display("FAIL drop_count_hold: got %0d want 2", bus.o_dropCount); end
  endtask

  task automatic test_grant_race();
    bit ok;
    doReset();
    bus.i_fifoNEntries = 6'd45;
    setCounts(1, 32'h00000011);
    bus.i_wrap = 4'b0010;
    tick();
    bus.i_wrap = '0;
    tick();
    checks++; if (bus.o_pending !== 4'b0010 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL race_setup: pending=%b busy=%b want 0010 0", bus.o_pending, bus.o_busy); end
    bus.i_fifoNEntries = '0;
    setCounts(1, 32'h00000022);
    bus.i_wrap = 4'b0010;
    tick();
    bus.i_wrap = '0;
    checks++; if (bus.o_busy !== 1'b1 || bus.o_pending !== 4'b0010) begin errors++; $display("FAIL race_recapture: busy=%b pending=%b want 1 0010", bus.o_busy, bus.o_pending); end
    capPacket(ok);
    checks++; if (!ok || pkt[0] !== 8'd1 || pkt[1] !== 8'd0 || pkt[2] !== 8'h11) begin errors++; $display("FAIL race_old_pkt: ok=%0d ch=%h win=%h x=%h want 01 00 11", ok, pkt[0], pkt[1], pkt[2]); end
    capPacket(ok);
    checks++; if (!ok || pkt[0] !== 8'd1 || pkt[1] !== 8'd1 || pkt[2] !== 8'h22) begin errors++; $display("FAIL race_new_pkt: ok=%0d ch=%h win=%h x=%h want 01 01 22", ok, pkt[0], pkt[1], pkt[2]); end
    checks++; if (bus.o_dropCount !== 8'd0) begin errors++; $display("FAIL race_nodrop: got %0d want 0", bus.o_dropCount); end
  endtask

  task automatic test_flush();
    bit ok;
    doReset();
    setCounts(0, 32'h0D0C0B0A);
    setCounts(1, 32'h0000000B);
    bus.i_wrap = 4'b0011;
    tick();
    bus.i_wrap = 4'b0010;   // ch1 still pending -> drop
    tick();
    bus.i_wrap = '0;
    ticks(3);
    checks++; if (bus.o_push !== 1'b1 || bus.o_data !== 8'h0B) begin errors++; $display("FAIL flush_byte3: push=%b data=%h want 1 0b", bus.o_push, bus.o_data); end
    checks++; if (bus.o_dropCount !== 8'd1 || bus.o_pending !== 4'b0010) begin errors++; $display("FAIL flush_pre: drop=%0d pending=%b want 1 0010", bus.o_dropCount, bus.o_pending); end
    flush      = 1'b1;
    bus.i_wrap = 4'b0100;   // discarded by the flush
    tick();
    flush      = 1'b0;
    bus.i_wrap = '0;
    checks++; if (bus.o_push !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL flush_push: push=%b busy=%b want 0 0", bus.o_push, bus.o_busy); end
    checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL flush_pending: got %b want 0000", bus.o_pending); end
    checks++; if (bus.o_dropCount !== 8'd0) begin errors++; $display("FAIL flush_drop: got %0d want 0", bus.o_dropCount); end
    setCounts(0, 32'h0000005A);
    setCounts(1, 32'h0000005B);
    bus.i_wrap = 4'b0011;
    tick();
    bus.i_wrap = '0;
    capPacket(ok);
    checks++; if (!ok || pkt[0] !== 8'd0 || pkt[1] !== 8'd1 || pkt[2] !== 8'h5A) begin errors++; $display("FAIL flush_after_ch0: ok=%0d ch=%h win=%h x=%h want 00 01 5a", ok, pkt[0], pkt[1], pkt[2]); end
    capPacket(ok);
    checks++; if (!ok || pkt[0] !== 8'd1 || pkt[1] !== 8'd2 || pkt[2] !== 8'h5B) begin errors++; $display("FAIL flush_after_ch1: ok=%0d ch=%h win=%h x=%h want 01 02 5b", ok, pkt[0], pkt[1], pkt[2]); end
    setCounts(2, 32'h0000005C);
    bus.i_wrap = 4'b0100;
    tick();
    bus.i_wrap = '0;
    capPacket(ok);
    checks++; if (!ok || pkt[0] !== 8'd2 || pkt[1] !== 8'd1) begin errors++; $display("FAIL flush_after_ch2: ok=%0d ch=%h win=%h want 02 01", ok, pkt[0], pkt[1]); end
  endtask

  task automatic test_clock_gate();
    logic [7:0] rest [3] = '{8'h22, 8'h33, 8'h44};
    doReset();
    setCounts(3, 32'h44332211);
    bus.i_wrap = 4'b1000;
    tick();
    bus.i_wrap = '0;
    tick();
    checks++; if (bus.o_push !== 1'b1 || bus.o_data !== 8'h03) begin errors++; $display("FAIL cg_byte0: push=%b data=%h want 1 03", bus.o_push, bus.o_data); end
    ticks(2);
    cg = 1'b0;
    #1;
    checks++; if (bus.o_push !== 1'b0) begin errors++; $display("FAIL cg_mask: push=%b want 0", bus.o_push); end
    bus.i_wrap = 4'b0001;   // ignored while gated
    ticks(2);
    bus.i_wrap = '0;
    checks++; if (bus.o_push !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_data !== 8'h11) begin errors++; $display("FAIL cg_frozen: push=%b busy=%b data=%h want 0 1 11", bus.o_push, bus.o_busy, bus.o_data); end
    checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL cg_wrap_ignored: pending=%b want 0000", bus.o_pending); end
    cg = 1'b1;
    #1;
    checks++; if (bus.o_push !== 1'b1 || bus.o_data !== 8'h11) begin errors++; $display("FAIL cg_resume: push=%b data=%h want 1 11", bus.o_push, bus.o_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.o_push !== 1'b1 || bus.o_data !== rest[k]) begin errors++; $display("FAIL cg_tail%0d: push=%b data=%h want 1 %h", k, bus.o_push, bus.o_data, rest[k]); end
    end
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL cg_end: busy=%b want 0", bus.o_busy); end
  endtask

  task automatic test_saturation();
    doReset();
    bus.i_fifoNEntries = 6'd45;
    bus.i_wrap = 4'b1111;
    tick();                 // all four captured
    tick();                 // four simultaneous drops
    checks++; if (bus.o_dropCount !== 8'd4) begin errors++; $display("FAIL sat_multi: got %0d want 4", bus.o_dropCount); end
    ticks(62);
    checks++; if (bus.o_dropCount !== 8'd252) begin errors++; $display("FAIL sat_252: got %0d want 252", bus.o_dropCount); end
    tick();
    checks++; if (bus.o_dropCount !== 8'd255) begin errors++; $display("FAIL sat_cross: got %0d want 255", bus.o_dropCount); end
    ticks(11);              // 300 drops in total
    bus.i_wrap = '0;
    checks++; if (bus.o_dropCount !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", bus.o_dropCount); end
  endtask

  initial begin
    test_reset();
    test_single_wrap();
    test_round_robin();
    test_drop_gap();
    test_grant_race();
    test_flush();
    test_clock_gate();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/corr_pkt_arbiter.md
# corr_pkt_arbiter

Round-robin packet scheduler that shares one byte-wide packet FIFO between `N_CHAN` correlator channels. Each channel strobes a window wrap together with its four 8-bit count bytes. The block holds one pending packet per channel and, when the FIFO has room, serializes the granted packet into the FIFO push port as six consecutive bytes. Wraps that arrive while a channel's slot is still occupied are counted as drops, and the window number still advances so the host can detect the gap.

## Interface
Parameters:
- `N_CHAN`, default 4: number of correlator channels, legal range 1..16.
- `FIFO_DEPTH`, default 50: depth of the downstream FIFO in bytes; must be at least 6.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset; synchronous, active-high.
- `i_cg`, in, 1: clock-gate enable. When low, all state holds and `o_push` is forced to 0.
- `i_flush`, in, 1: synchronous abort of all pending and in-flight packets.
- `i_wrap`, in, `N_CHAN`: per-channel window-wrap strobe.
- `i_counts`, in, `32*N_CHAN`: per-channel bytes `{symdiff,isect,y,x}`; channel c is at `[32*c +: 32]`. Sampled only when `i_wrap[c]` is high.
- `i_fifoNEntries`, in, `$clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `o_push`, out, 1: FIFO push strobe.
- `o_data`, out, 8: FIFO push data.
- `o_busy`, out, 1: high while the FSM is in EMIT.
- `o_pending`, out, `N_CHAN`: per-channel slot-occupied flags.
- `o_dropCount`, out, 8: saturating count of dropped wraps across all channels.

## Operation
- Per-channel state: `pending` (1 bit), `shadow` (32 bits), `winNumShadow` (8 bits), `winNum` counter (8 bits, wrapping).
- `winNum[c]` increments on every `i_wrap[c]` when `i_cg` is high, whether the wrap is captured, dropped or flushed.
- Capture: `i_wrap[c]` with `pending[c]==0`, or with channel c being granted in the same cycle.
  - Load `shadow` from `i_counts[c]` and `winNumShadow` from `winNum[c]` (the pre-increment value).
  - Set `pending[c]`.
- Drop: `i_wrap[c]` with `pending[c]==1` and no grant to channel c that cycle.
  - Shadow is unchanged.
  - `o_dropCount` increments, saturating at 255.
  - Multiple simultaneous drops in one cycle add their total, still saturating.
- Packet format, 6 bytes in order: channel index (zero-extended), `winNumShadow`, x, y, isect, symdiff.
- FSM has two states, IDLE and EMIT, plus `rrPtr` and a 3-bit `byteIdx`.
- IDLE:
  - Grant condition: `|pending` and `i_fifoNEntries + 6 <= FIFO_DEPTH`, computed one bit wider to avoid overflow.
  - On grant, select the first pending channel searching upward from `rrPtr` with wrap-around.
  - Copy that channel's shadow and winNumShadow into a 48-bit packet buffer, clear its `pending`, set `rrPtr = granted+1 mod N_CHAN`, set `byteIdx = 0`, and go to EMIT.
- EMIT:
  - `o_push = 1` and `o_data = buf byte[byteIdx]`; `byteIdx` increments each cycle.
  - After the cycle with `byteIdx==5`, return to IDLE.
  - No re-grant occurs in that same cycle.
- The space check at grant time guarantees all 6 bytes fit, because FIFO pops only free space. No push is ever made to a full FIFO.
- Flush (`i_flush` with `i_cg`):
  - Clears all `pending`, `byteIdx`, `rrPtr` and `o_dropCount`, and returns the FSM to IDLE.
  - `winNum` counters and shadows are retained.
  - A wrap in the same cycle is discarded and not counted as a drop.
  - A partial packet already in the FIFO is the FIFO's own flush responsibility; the same `i_flush` drives both blocks.
- Reset has priority over flush.

## Timing
- Reset values:
  - `o_push=0`, `o_data=0` (buffer reset to 0), `o_busy=0`, `o_pending=0`, `o_dropCount=0`.
  - All `winNum` counters 0, `rrPtr` 0, FSM in IDLE.
- `i_wrap[c]` at cycle t sets `pending[c]` at t+1.
- If the FIFO has room, the grant occurs at t+1 and bytes are pushed at t+2 through t+7.
- Minimum packet period is 7 cycles: one grant cycle plus six EMIT cycles.
- All outputs are registered, except that `o_push` is `busy && i_cg`.
- While `i_cg` is low, nothing advances, including `winNum`, and `i_wrap` is ignored.
- Reset mid-packet abandons the packet immediately; the next cycle has `o_push=0`.

## Test plan
- Single wrap:
  - Stimulus: `N_CHAN=4`, empty FIFO; `i_wrap=4'b0100` with counts `0x44332211` at cycle 10.
  - Required: pushes at cycles 12–17 with data `02,00,11,22,33,44`; `o_busy` high for cycles 12–17.
- Round-robin fairness:
  - Stimulus: all four channels wrap in the same cycle.
  - Required: packets emitted in channel order 0,1,2,3; after granting 1, a new wrap on 0 and 2 is serviced as 2 then 0.
- Drop and gap:
  - Stimulus: hold `i_fifoNEntries=45` (no room); channel 0 wraps 3 times.
  - Required: `o_dropCount=2`. After releasing to 0, the packet header shows `winNum=0`; the next wrap's packet shows `winNum=3`.
- Grant/capture race:
  - Stimulus: a wrap on channel 1 in the exact cycle channel 1 is granted.
  - Required: the old packet is emitted, then a second packet with the new counts; no drop counted.
- Flush mid-packet:
  - Stimulus: assert `i_flush` during byte 3 with two channels pending.
  - Required: next cycle `o_push=0`, `o_pending=0`, `o_dropCount=0`; `winNum` values continue from before the flush.
- Clock gate and saturation:
  - Stimulus: `i_cg=0` during EMIT; separately, force 300 drops.
  - Required: with the gate low, `byteIdx` freezes and there are no pushes, and emission resumes at the next byte when the gate returns high. `o_dropCount` stays at 255.
